// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the N-way instruction cache.
// Helpers return 32-bit values; callers size-cast to the field width they need.
package icache_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StRefill, StCommit} state_e;

  function automatic int unsigned words(input int unsigned offset_len);
    return 32'd1 << (offset_len - 2);
  endfunction

  function automatic int unsigned sets(input int unsigned index_len);
    return 32'd1 << index_len;
  endfunction

  // A single-way cache keeps an unused 1-bit vector so array widths stay non-zero.
  function automatic int unsigned plru_w(input int unsigned way_cnt);
    return (way_cnt > 1) ? way_cnt - 1 : 1;
  endfunction

  function automatic int unsigned way_w(input int unsigned way_cnt);
    return (way_cnt > 1) ? $clog2(way_cnt) : 1;
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned offset_len,
                                           input int unsigned index_len);
    return a >> (offset_len + index_len);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int unsigned offset_len,
                                             input int unsigned index_len);
    return (a >> offset_len) & ((32'd1 << index_len) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] a, input int unsigned offset_len);
    return (a >> 2) & ((32'd1 << (offset_len - 2)) - 32'd1);
  endfunction

  function automatic logic [31:0] line_addr(input logic [31:0] a, input int unsigned offset_len);
    return (a >> offset_len) << offset_len;
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_nway_if;
  logic [31:0] addr;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        miss;
  logic        inv_all;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;

  modport slave (
    input  addr, rd_req, inv_all, mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    output rd_data, miss, mem_req, mem_addr
  );

  modport master (
    output addr, rd_req, inv_all, mem_gnt, mem_rvalid, mem_rdata, mem_rlast,
    input  rd_data, miss, mem_req, mem_addr
  );
endinterface

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim walk and access update for one set.
// Bit 0 is the root, children of node i are 2i+1 / 2i+2, a 0 bit points left.
module plru_tree
  import icache_pkg::*;
#(
  parameter int unsigned WAY_CNT = 4
) (
  input  logic [plru_w(WAY_CNT)-1:0] bits,
  input  logic [way_w(WAY_CNT)-1:0]  access_way,
  output logic [way_w(WAY_CNT)-1:0]  victim,
  output logic [plru_w(WAY_CNT)-1:0] next_bits
);
  localparam int Levels = $clog2(WAY_CNT);

  if (WAY_CNT == 1) begin : g_single
    logic unused_access;
    assign unused_access = ^access_way;
    assign victim        = '0;
    assign next_bits     = bits;
  end else begin : g_tree
    always_comb begin
      int node;
      victim = '0;
      node   = 0;
      for (int l = 0; l < Levels; l++) begin
        victim[Levels-1-l] = bits[node];
        node = 2 * node + 1 + int'(bits[node]);
      end
    end

    // Each node on the accessed path is turned to point away from that way.
    always_comb begin
      int   node;
      logic dir;
      next_bits = bits;
      node      = 0;
      for (int l = 0; l < Levels; l++) begin
        dir             = access_way[Levels-1-l];
        next_bits[node] = ~dir;
        node            = 2 * node + 1 + int'(dir);
      end
    end
  end
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with beat-wise line refill,
// first-invalid / tree-PLRU replacement and whole-cache invalidate.
module icache_nway
  import icache_pkg::*;
#(
  parameter int unsigned OFFSET_LEN = 5,
  parameter int unsigned INDEX_LEN  = 7,
  parameter int unsigned WAY_CNT    = 4
) (
  input logic          clk,
  input logic          rst,
  icache_nway_if.slave bus
);
  localparam int unsigned TAG_LEN = 32 - INDEX_LEN - OFFSET_LEN;
  localparam int unsigned WORDS   = words(OFFSET_LEN);
  localparam int unsigned SETS    = sets(INDEX_LEN);
  localparam int unsigned PLRU_W  = plru_w(WAY_CNT);
  localparam int unsigned WAY_W   = way_w(WAY_CNT);
  localparam int unsigned WORD_W  = OFFSET_LEN - 2;

  state_e              state_q, state_d;
  logic [31:0]         miss_addr_q, miss_addr_d;
  logic [WORD_W-1:0]   beat_q, beat_d;
  logic                flush_q, flush_d;
  logic [31:0]         line_q  [WORDS];
  logic [WAY_CNT-1:0]  valid_q [SETS];
  logic [PLRU_W-1:0]   plru_q  [SETS];
  logic [TAG_LEN-1:0]  tag_q   [WAY_CNT][SETS];
  logic [31:0]         data_q  [WAY_CNT][SETS][WORDS];

  logic [TAG_LEN-1:0]   req_tag, miss_tag;
  logic [INDEX_LEN-1:0] req_idx, miss_idx;
  logic [WORD_W-1:0]    req_word;
  logic [WAY_CNT-1:0]   hit;
  logic [WAY_W-1:0]     hit_way, victim, plru_victim, unused_hit_victim;
  logic [31:0]          hit_data;
  logic                 lookup_hit, clear_valid, commit, plru_hit_we, beat_we, unused_rlast;
  logic [PLRU_W-1:0]    hit_plru_next, fill_plru_next;

  assign req_tag      = TAG_LEN'(addr_tag(bus.addr, OFFSET_LEN, INDEX_LEN));
  assign req_idx      = INDEX_LEN'(addr_index(bus.addr, OFFSET_LEN, INDEX_LEN));
  assign req_word     = WORD_W'(addr_word(bus.addr, OFFSET_LEN));
  assign miss_tag     = TAG_LEN'(addr_tag(miss_addr_q, OFFSET_LEN, INDEX_LEN));
  assign miss_idx     = INDEX_LEN'(addr_index(miss_addr_q, OFFSET_LEN, INDEX_LEN));
  assign unused_rlast = bus.mem_rlast;

  always_comb begin
    hit      = '0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < int'(WAY_CNT); w++) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit[w]   = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = hit_data | data_q[w][req_idx][req_word];
      end
    end
  end

  // A pending flush forces the first IDLE lookup after COMMIT to miss.
  assign lookup_hit  = (|hit) && !flush_q;
  assign bus.rd_data = rst ? hit_data : '0;
  assign bus.miss    = rst && bus.rd_req && ((state_q != StIdle) || !lookup_hit);

  plru_tree #(.WAY_CNT(WAY_CNT)) u_plru_hit (
    .bits       (plru_q[req_idx]),
    .access_way (hit_way),
    .victim     (unused_hit_victim),
    .next_bits  (hit_plru_next)
  );

  plru_tree #(.WAY_CNT(WAY_CNT)) u_plru_fill (
    .bits       (plru_q[miss_idx]),
    .access_way (victim),
    .victim     (plru_victim),
    .next_bits  (fill_plru_next)
  );

  always_comb begin
    victim = plru_victim;
    for (int w = int'(WAY_CNT) - 1; w >= 0; w--) begin
      if (!valid_q[miss_idx][w]) victim = WAY_W'(w);
    end
  end

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    beat_d       = beat_q;
    flush_d      = flush_q;
    clear_valid  = 1'b0;
    commit       = 1'b0;
    plru_hit_we  = 1'b0;
    beat_we      = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    case (state_q)
      StIdle: begin
        if (flush_q || bus.inv_all) begin
          clear_valid = 1'b1;
          flush_d     = 1'b0;
        end
        if (bus.rd_req) begin
          if (lookup_hit) begin
            plru_hit_we = 1'b1;
          end else begin
            miss_addr_d = line_addr(bus.addr, OFFSET_LEN);
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = miss_addr_q;
        if (bus.mem_gnt) begin
          beat_d  = '0;
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (bus.mem_rvalid) begin
          beat_we = 1'b1;
          beat_d  = beat_q + 1'b1;
          if (beat_q == WORD_W'(WORDS - 1)) state_d = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if ((state_q != StIdle) && bus.inv_all) flush_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      beat_q      <= '0;
      flush_q     <= 1'b0;
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      for (int i = 0; i < int'(WORDS); i++) line_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      beat_q      <= beat_d;
      flush_q     <= flush_d;
      if (beat_we) line_q[beat_q] <= bus.mem_rdata;
      if (clear_valid) begin
        for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
      end else if (commit) begin
        valid_q[miss_idx][victim] <= 1'b1;
      end
      if (commit) begin
        plru_q[miss_idx] <= fill_plru_next;
      end else if (plru_hit_we) begin
        plru_q[req_idx] <= hit_plru_next;
      end
    end
  end

  // Tag and data arrays need no reset: valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (commit) begin
      tag_q[victim][miss_idx] <= miss_tag;
      for (int i = 0; i < int'(WORDS); i++) data_q[victim][miss_idx][i] <= line_q[i];
    end
  end
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: table of hit vectors plus refill/flush/reset sequences.
module tb_icache_nway;
  localparam int WORDS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  icache_nway_if bus ();

  icache_nway #(
    .OFFSET_LEN (5),
    .INDEX_LEN  (7),
    .WAY_CNT    (4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  typedef struct {
    logic        rd_req;
    logic [31:0] addr;
    logic        exp_miss;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic miss_to_req(input logic [31:0] line);
    int k;
    #1;
    chk("miss_idle", 32'(bus.miss), 32'd1);
    k = 0;
    cyc();
    while (!bus.mem_req && k < 20) begin
      cyc();
      k++;
    end
    chk("mem_req_up", 32'(bus.mem_req), 32'd1);
    chk("mem_addr", bus.mem_addr, line);
    chk("miss_req", 32'(bus.miss), 32'd1);
  endtask

  task automatic grant(input int wait_n);
    repeat (wait_n) begin
      chk("req_hold", 32'(bus.mem_req), 32'd1);
      cyc();
    end
    bus.mem_gnt = 1'b1;
    cyc();
    bus.mem_gnt = 1'b0;
  endtask

  task automatic beats(input logic [31:0] base, input int first, input int last_i,
                       input bit gap, input int inv_at);
    for (int i = first; i <= last_i; i++) begin
      if (gap) cyc();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(i);
      bus.mem_rlast  = (i == WORDS - 1);
      bus.inv_all    = (i == inv_at);
      cyc();
      bus.mem_rvalid = 1'b0;
      bus.mem_rlast  = 1'b0;
      bus.inv_all    = 1'b0;
    end
  endtask

  task automatic do_miss(input logic [31:0] line, input logic [31:0] base, input int gnt_wait,
                         input bit gap, input int inv_at, input logic [31:0] addr_during,
                         input int exp_pen);
    int start;
    start = ncyc;
    miss_to_req(line);
    grant(gnt_wait);
    if (addr_during != 0) bus.addr = addr_during;
    beats(base, 0, WORDS - 1, gap, inv_at);
    chk("miss_commit", 32'(bus.miss), 32'd1);
    cyc();
    chk("penalty", 32'(ncyc - start), 32'(exp_pen));
  endtask

  // Continuous protocol checks.
  always @(negedge clk) begin
    if (!bus.rd_req) chk("miss_without_req", 32'(bus.miss), 32'd0);
    if (!bus.mem_req) chk("mem_addr_idle", bus.mem_addr, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] lines [4];
    logic [31:0] bases [4];
    lines = '{32'h80, 32'h1080, 32'h2080, 32'h3080};
    bases = '{32'h10, 32'h20, 32'h30, 32'h40};

    vecs[0] = '{1'b1, 32'h0000_0080, 1'b0, 32'h10};
    vecs[1] = '{1'b1, 32'h0000_0084, 1'b0, 32'h11};
    vecs[2] = '{1'b1, 32'h0000_1080, 1'b0, 32'h20};
    vecs[3] = '{1'b1, 32'h0000_3088, 1'b0, 32'h42};
    vecs[4] = '{1'b1, 32'h0000_409C, 1'b0, 32'h57};
    vecs[5] = '{1'b1, 32'h0000_1010, 1'b0, 32'hA4};
    vecs[6] = '{1'b0, 32'h0000_2080, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0090, 1'b0, 32'h14};

    bus.addr       = 32'h0000_1004;
    bus.rd_req     = 1'b1;
    bus.inv_all    = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_rlast  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_miss", 32'(bus.miss), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rst_n = 1'b1;

    // Cold miss
    do_miss(32'h0000_1000, 32'hA0, 1, 1'b0, -1, 32'h0, 12);
    chk("cold_hit_miss", 32'(bus.miss), 32'd0);
    chk("cold_hit_data", bus.rd_data, 32'hA1);
    bus.addr = 32'h0000_101C;
    #1;
    chk("cold_last_miss", 32'(bus.miss), 32'd0);
    chk("cold_last_data", bus.rd_data, 32'hA7);
    cyc();

    // PLRU victim selection in set 4
    for (int k = 0; k < 4; k++) begin
      bus.addr = lines[k];
      do_miss(lines[k], bases[k], 0, 1'b0, -1, 32'h0, 11);
      chk("fill_data", bus.rd_data, bases[k]);
    end
    bus.addr = 32'h0000_0080;
    #1;
    chk("plru_touch", bus.rd_data, 32'h10);
    cyc();
    bus.addr = 32'h0000_4080;
    do_miss(32'h0000_4080, 32'h50, 0, 1'b0, -1, 32'h0, 11);
    bus.addr = 32'h0000_2080;
    #1;
    chk("evicted_way2", 32'(bus.miss), 32'd1);

    for (int i = 0; i < 8; i++) begin
      bus.rd_req = vecs[i].rd_req;
      bus.addr   = vecs[i].addr;
      #1;
      chk($sformatf("tbl%0d_miss", i), 32'(bus.miss), 32'(vecs[i].exp_miss));
      chk($sformatf("tbl%0d_data", i), bus.rd_data, vecs[i].exp_data);
      cyc();
    end

    // Flush in IDLE: same-cycle lookup still hits
    bus.rd_req  = 1'b1;
    bus.addr    = 32'h0000_1000;
    bus.inv_all = 1'b1;
    #1;
    chk("flush_same_miss", 32'(bus.miss), 32'd0);
    chk("flush_same_data", bus.rd_data, 32'hA0);
    cyc();
    bus.inv_all = 1'b0;
    bus.addr    = 32'h0000_0080;
    #1;
    chk("flushed_set4", 32'(bus.miss), 32'd1);
    bus.addr = 32'h0000_1000;
    do_miss(32'h0000_1000, 32'hC0, 0, 1'b0, -1, 32'h0, 11);
    chk("reload_data", bus.rd_data, 32'hC0);

    // Flush mid-refill: line commits, then the next IDLE lookup misses
    bus.addr = 32'h0000_2000;
    do_miss(32'h0000_2000, 32'hD0, 0, 1'b0, 3, 32'h0, 11);
    do_miss(32'h0000_2000, 32'hE0, 0, 1'b0, -1, 32'h0, 11);
    chk("after_flush_data", bus.rd_data, 32'hE0);
    bus.addr = 32'h0000_1000;
    #1;
    chk("after_flush_other", 32'(bus.miss), 32'd1);
    bus.rd_req = 1'b0;
    cyc();

    // Async reset mid-refill
    bus.rd_req = 1'b1;
    bus.addr   = 32'h0000_3000;
    miss_to_req(32'h0000_3000);
    grant(0);
    beats(32'h60, 0, 3, 1'b0, -1);
    bus.addr = 32'h0000_2000;
    rst_n    = 1'b0;
    #1;
    chk("amid_miss", 32'(bus.miss), 32'd0);
    chk("amid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("amid_mem_addr", bus.mem_addr, 32'd0);
    chk("amid_rd_data", bus.rd_data, 32'd0);
    cyc();
    rst_n      = 1'b1;
    bus.rd_req = 1'b0;
    repeat (3) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_0000;
      cyc();
      chk("stray_no_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_rvalid = 1'b0;
    bus.rd_req     = 1'b1;
    #1;
    chk("post_reset_miss", 32'(bus.miss), 32'd1);
    bus.addr = 32'h0000_3000;
    do_miss(32'h0000_3000, 32'hF0, 0, 1'b0, -1, 32'h0, 11);
    bus.addr = 32'h0000_3004;
    #1;
    chk("post_reset_data", bus.rd_data, 32'hF1);
    cyc();

    // Backpressure: late grant, gapped beats, address moves during refill
    bus.addr = 32'h0000_1000;
    do_miss(32'h0000_1000, 32'hB0, 5, 1'b1, -1, 32'h0000_2000, 24);
    chk("new_addr_miss", 32'(bus.miss), 32'd1);
    for (int i = 0; i < WORDS; i++) begin
      bus.addr = 32'h0000_1000 + 32'(4 * i);
      #1;
      chk($sformatf("bp_word%0d", i), bus.rd_data, 32'hB0 + 32'(i));
      cyc();
    end
    bus.addr = 32'h0000_3000;
    #1;
    chk("bp_other_way", bus.rd_data, 32'hF0);
    bus.rd_req = 1'b0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
